// File: rtl/ready_valid_if.sv
// Ready/valid stream bundle: the producer drives valid and data, the consumer drives ready.
interface ready_valid_i #(
    parameter int DATA_WIDTH = 8
);
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;

    modport m (output valid, output data, input ready);
    modport s (input valid, input data, output ready);
endinterface

// File: rtl/ready_valid_merger.sv
// N-to-1 ready/valid fan-in with round-robin arbitration and a registered output stage
// that carries the index of the source that produced each beat.
module ready_valid_merger #(
    parameter int NUM_INTERFACES = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int SEL_WIDTH      = (NUM_INTERFACES > 1) ? $clog2(NUM_INTERFACES) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ready_valid_i.s              in [NUM_INTERFACES],
    ready_valid_i.m              out,
    output logic [SEL_WIDTH-1:0] out_sel
);
    // After reset the search starts just past the top index, so input 0 wins first.
    localparam logic [SEL_WIDTH-1:0] LAST_RESET = SEL_WIDTH'(NUM_INTERFACES - 1);

    logic [NUM_INTERFACES-1:0] in_valid;
    logic [NUM_INTERFACES-1:0] grant;
    logic [DATA_WIDTH-1:0]     in_data [NUM_INTERFACES];
    logic [SEL_WIDTH-1:0]      last_q;
    logic [SEL_WIDTH-1:0]      grant_idx;
    logic [SEL_WIDTH-1:0]      sel_q;
    logic [DATA_WIDTH-1:0]     data_q;
    logic                      valid_q;
    logic                      any_valid;
    logic                      load_en;

    for (genvar g = 0; g < NUM_INTERFACES; g++) begin : g_in
        assign in_valid[g] = in[g].valid;
        assign in_data[g]  = in[g].data;
        assign in[g].ready = load_en && grant[g];
    end

    assign any_valid = |in_valid;
    assign load_en   = rst_n && (!valid_q || out.ready);

    always_comb begin
        int   idx;
        logic found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 1; k <= NUM_INTERFACES; k++) begin
            idx = (int'(last_q) + k) % NUM_INTERFACES;
            if (!found && in_valid[idx]) begin
                found          = 1'b1;
                grant[idx]     = 1'b1;
                grant_idx      = SEL_WIDTH'(idx);
            end
        end
    end

    // The pointer only moves on an accepted input beat, so a stall never skips anyone.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            sel_q   <= '0;
            last_q  <= LAST_RESET;
        end else if (load_en) begin
            valid_q <= any_valid;
            if (any_valid) begin
                sel_q  <= grant_idx;
                last_q <= grant_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (load_en && any_valid) begin
            data_q <= in_data[grant_idx];
        end
    end

    assign out.valid = valid_q;
    assign out.data  = data_q;
    assign out_sel   = sel_q;
endmodule

// File: tb/tb_ready_valid_merger.sv
// Directed and scoreboarded checks of the round-robin merger, with a 4-input and a 1-input instance.
module tb_ready_valid_merger;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       out_ready;
    logic [3:0] drv_valid;
    logic [7:0] drv_data [4];
    logic [3:0] obs_ready;
    logic [1:0] out_sel;

    logic       out1_ready;
    logic       drv1_valid;
    logic [7:0] drv1_data;
    logic       obs1_ready;
    logic [0:0] out1_sel;

    int passed = 0;
    int total  = 0;

    ready_valid_i #(.DATA_WIDTH(8)) in_if [4] ();
    ready_valid_i #(.DATA_WIDTH(8)) out_if ();
    ready_valid_i #(.DATA_WIDTH(8)) in1_if [1] ();
    ready_valid_i #(.DATA_WIDTH(8)) out1_if ();

    for (genvar g = 0; g < 4; g++) begin : g_drv
        assign in_if[g].valid = drv_valid[g];
        assign in_if[g].data  = drv_data[g];
        assign obs_ready[g]   = in_if[g].ready;
    end
    assign out_if.ready    = out_ready;
    assign in1_if[0].valid = drv1_valid;
    assign in1_if[0].data  = drv1_data;
    assign obs1_ready      = in1_if[0].ready;
    assign out1_if.ready   = out1_ready;

    ready_valid_merger #(.NUM_INTERFACES(4), .DATA_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in(in_if), .out(out_if), .out_sel(out_sel)
    );

    ready_valid_merger #(.NUM_INTERFACES(1), .DATA_WIDTH(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .in(in1_if), .out(out1_if), .out_sel(out1_sel)
    );

    task automatic set_all_data();
        for (int j = 0; j < 4; j++) drv_data[j] = 8'hA0 + 8'(j);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; out_ready = 1'b1; drv_valid = 4'hF; set_all_data();
        out1_ready = 1'b1; drv1_valid = 1'b1; drv1_data = 8'h00;
        @(posedge clk); #1; @(posedge clk); #1;
        total++; if (out_if.valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", out_if.valid); else passed++;
        total++; if (out_sel !== 2'd0) $display("[TB] FAIL reset_sel: got %0d expected 0", out_sel); else passed++;
        total++; if (obs_ready !== 4'b0000) $display("[TB] FAIL reset_ready: got %b expected 0000", obs_ready); else passed++;
        total++; if (out1_if.valid !== 1'b0) $display("[TB] FAIL reset_n1_valid: got %b expected 0", out1_if.valid); else passed++;
        total++; if (obs1_ready !== 1'b0) $display("[TB] FAIL reset_n1_ready: got %b expected 0", obs1_ready); else passed++;
        drv_valid = 4'h0; drv1_valid = 1'b0; rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_round_robin();
        drv_valid = 4'hF; set_all_data(); out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            total++; if (obs_ready !== 4'(1 << (k % 4))) $display("[TB] FAIL rr_ready[%0d]: got %b expected %b", k, obs_ready, 4'(1 << (k % 4))); else passed++;
            @(posedge clk); #1;
            total++; if (out_if.valid !== 1'b1 || out_if.data !== 8'hA0 + 8'(k % 4) || out_sel !== 2'(k % 4))
                $display("[TB] FAIL rr_beat[%0d]: got v=%b d=%h sel=%0d expected v=1 d=%h sel=%0d", k, out_if.valid, out_if.data, out_sel, 8'hA0 + 8'(k % 4), k % 4);
            else passed++;
        end
        drv_valid = 4'h0;
        @(posedge clk); #1;
        total++; if (out_if.valid !== 1'b0) $display("[TB] FAIL rr_drain: got %b expected 0", out_if.valid); else passed++;
    endtask

    task automatic test_single_stream();
        drv_valid = 4'b0100; out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            drv_data[2] = 8'h20 + 8'(k);
            #1;
            total++; if (obs_ready !== 4'b0100) $display("[TB] FAIL stream_ready[%0d]: got %b expected 0100", k, obs_ready); else passed++;
            @(posedge clk); #1;
            total++; if (out_if.valid !== 1'b1 || out_if.data !== 8'h20 + 8'(k) || out_sel !== 2'd2)
                $display("[TB] FAIL stream_beat[%0d]: got v=%b d=%h sel=%0d expected v=1 d=%h sel=2", k, out_if.valid, out_if.data, out_sel, 8'h20 + 8'(k));
            else passed++;
        end
        drv_valid = 4'h0;
        @(posedge clk); #1;
    endtask

    task automatic test_stall();
        drv_valid = 4'b0010; drv_data[1] = 8'h55; out_ready = 1'b1;
        #1;
        total++; if (obs_ready !== 4'b0010) $display("[TB] FAIL stall_load_ready: got %b expected 0010", obs_ready); else passed++;
        @(posedge clk); #1;
        out_ready = 1'b0; drv_valid = 4'b1001; drv_data[0] = 8'h30; drv_data[3] = 8'h33;
        for (int k = 0; k < 5; k++) begin
            #1;
            total++; if (obs_ready !== 4'b0000) $display("[TB] FAIL stall_ready[%0d]: got %b expected 0000", k, obs_ready); else passed++;
            @(posedge clk); #1;
            total++; if (out_if.valid !== 1'b1 || out_if.data !== 8'h55 || out_sel !== 2'd1)
                $display("[TB] FAIL stall_hold[%0d]: got v=%b d=%h sel=%0d expected v=1 d=55 sel=1", k, out_if.valid, out_if.data, out_sel);
            else passed++;
        end
        out_ready = 1'b1;
        #1;
        total++; if (obs_ready !== 4'b1000) $display("[TB] FAIL stall_release_ready: got %b expected 1000", obs_ready); else passed++;
        @(posedge clk); #1;
        total++; if (out_if.valid !== 1'b1 || out_if.data !== 8'h33 || out_sel !== 2'd3)
            $display("[TB] FAIL stall_release_beat: got v=%b d=%h sel=%0d expected v=1 d=33 sel=3", out_if.valid, out_if.data, out_sel);
        else passed++;
        drv_valid = 4'b0001;
        #1;
        total++; if (obs_ready !== 4'b0001) $display("[TB] FAIL stall_next_ready: got %b expected 0001", obs_ready); else passed++;
        @(posedge clk); #1;
        total++; if (out_if.valid !== 1'b1 || out_if.data !== 8'h30 || out_sel !== 2'd0)
            $display("[TB] FAIL stall_next_beat: got v=%b d=%h sel=%0d expected v=1 d=30 sel=0", out_if.valid, out_if.data, out_sel);
        else passed++;
        drv_valid = 4'h0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        drv_valid = 4'b0001; drv_data[0] = 8'h77; out_ready = 1'b1;
        @(posedge clk); #1;
        drv_valid = 4'h0; out_ready = 1'b0;
        @(posedge clk); #1;
        total++; if (out_if.valid !== 1'b1 || out_if.data !== 8'h77)
            $display("[TB] FAIL midrst_held: got v=%b d=%h expected v=1 d=77", out_if.valid, out_if.data);
        else passed++;
        rst_n = 1'b0; drv_valid = 4'hF; set_all_data();
        #1;
        total++; if (obs_ready !== 4'b0000) $display("[TB] FAIL midrst_ready: got %b expected 0000", obs_ready); else passed++;
        @(posedge clk); #1;
        total++; if (out_if.valid !== 1'b0) $display("[TB] FAIL midrst_drop: got %b expected 0", out_if.valid); else passed++;
        rst_n = 1'b1; out_ready = 1'b1;
        #1;
        total++; if (obs_ready !== 4'b0001) $display("[TB] FAIL midrst_first_ready: got %b expected 0001", obs_ready); else passed++;
        @(posedge clk); #1;
        total++; if (out_if.valid !== 1'b1 || out_if.data !== 8'hA0 || out_sel !== 2'd0)
            $display("[TB] FAIL midrst_first_beat: got v=%b d=%h sel=%0d expected v=1 d=a0 sel=0", out_if.valid, out_if.data, out_sel);
        else passed++;
        drv_valid = 4'h0;
        @(posedge clk); #1;
    endtask

    task automatic test_single_interface();
        logic       m_valid;
        logic [7:0] m_data;
        logic       exp_rdy;
        m_valid = 1'b0; m_data = 8'h00;
        drv1_valid = 1'b1; drv1_data = 8'h10;
        for (int k = 0; k < 8; k++) begin
            out1_ready = (k % 2 == 0);
            #1;
            exp_rdy = !m_valid || out1_ready;
            total++; if (obs1_ready !== exp_rdy) $display("[TB] FAIL n1_ready[%0d]: got %b expected %b", k, obs1_ready, exp_rdy); else passed++;
            @(posedge clk); #1;
            if (exp_rdy) begin
                m_valid = 1'b1; m_data = drv1_data; drv1_data = drv1_data + 8'd1;
            end
            total++; if (out1_if.valid !== m_valid || out1_if.data !== m_data || out1_sel !== 1'b0)
                $display("[TB] FAIL n1_beat[%0d]: got v=%b d=%h sel=%0d expected v=%b d=%h sel=0", k, out1_if.valid, out1_if.data, out1_sel, m_valid, m_data);
            else passed++;
        end
        drv1_valid = 1'b0; out1_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int         seq [4];
        int         exp_seq [4];
        int         waitc [4];
        logic [3:0] acc, acc_prev;
        logic [1:0] src;
        int         sent, recv, onehot_err, wait_err, order_err, sel_err;
        bit         stop_gen, done;
        for (int j = 0; j < 4; j++) begin seq[j] = 0; exp_seq[j] = 0; waitc[j] = 0; end
        acc = '0; acc_prev = '0; drv_valid = 4'h0;
        sent = 0; recv = 0; onehot_err = 0; wait_err = 0; order_err = 0; sel_err = 0;
        stop_gen = 1'b0; done = 1'b0;
        for (int cyc = 0; cyc < 80000 && !done; cyc++) begin
            for (int j = 0; j < 4; j++) begin
                if (acc_prev[j]) begin
                    seq[j] = (seq[j] + 1) % 64;
                    drv_valid[j] = stop_gen ? 1'b0 : 1'($urandom_range(0, 1));
                end else if (!drv_valid[j] && !stop_gen) begin
                    drv_valid[j] = 1'($urandom_range(0, 1));
                end
                drv_data[j] = {2'(j), 6'(seq[j])};
            end
            out_ready = stop_gen ? 1'b1 : ($urandom_range(0, 9) < 3);
            #1;
            acc = drv_valid & obs_ready;
            if ($countones(acc) > 1) onehot_err++;
            if (acc != 4'h0) begin
                sent += $countones(acc);
                for (int j = 0; j < 4; j++) begin
                    if (acc[j]) waitc[j] = 0;
                    else if (drv_valid[j]) begin
                        waitc[j]++;
                        if (waitc[j] > 3) wait_err++;
                    end
                end
            end
            if (out_if.valid && out_ready) begin
                src = out_if.data[7:6];
                if (out_sel !== src) sel_err++;
                if (int'(out_if.data[5:0]) != exp_seq[src]) order_err++;
                exp_seq[src] = (exp_seq[src] + 1) % 64;
                recv++;
                if (recv >= 10000) stop_gen = 1'b1;
            end
            @(posedge clk); #1;
            acc_prev = acc;
            if (stop_gen && ((drv_valid & ~acc) == 4'h0) && !out_if.valid) done = 1'b1;
        end
        drv_valid = 4'h0;
        total++; if (!done) $display("[TB] FAIL rand_timeout: got recv=%0d expected completion within cycle budget", recv); else passed++;
        total++; if (onehot_err != 0) $display("[TB] FAIL rand_onehot: got %0d multi-ready cycles expected 0", onehot_err); else passed++;
        total++; if (wait_err != 0) $display("[TB] FAIL rand_wait: got %0d waits over 3 beats expected 0", wait_err); else passed++;
        total++; if (order_err != 0) $display("[TB] FAIL rand_order: got %0d out-of-order beats expected 0", order_err); else passed++;
        total++; if (sel_err != 0) $display("[TB] FAIL rand_sel: got %0d sel mismatches expected 0", sel_err); else passed++;
        total++; if (recv != sent) $display("[TB] FAIL rand_count: got recv=%0d expected sent=%0d", recv, sent); else passed++;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_stream();
        test_stall();
        test_reset_mid();
        test_single_interface();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
